// File: rtl/pong_pkg.sv
// Shared Pong definitions: match states, score width, field centre, point-award helper.
// PONG_WIN_BY_TWO_EN selects win-by-two scoring with deuce fold.
package pong_pkg;

  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;

  localparam int unsigned SCORE_W  = 4;
  localparam int unsigned CENTRE_X = 320;
  localparam int unsigned CENTRE_Y = 240;

  typedef struct packed {
    logic [SCORE_W-1:0] scorer;
    logic [SCORE_W-1:0] other;
    logic               win;
  } pt_res_t;

  // Score one point for 'scorer'; returns the new nibbles and whether the match ends.
  function automatic pt_res_t award_point(input logic [SCORE_W-1:0] scorer,
                                          input logic [SCORE_W-1:0] other,
                                          input logic [SCORE_W-1:0] win_score);
    pt_res_t r;
    r.scorer = scorer + 4'd1;
    r.other  = other;
`ifdef PONG_WIN_BY_TWO_EN
    r.win = (r.scorer >= win_score) && ({1'b0, r.scorer} >= {1'b0, r.other} + 5'd2);
    // Tie above WIN_SCORE-1 folds back to WIN_SCORE-1 each so nibbles never wrap.
    if ((r.scorer == r.other) && (r.scorer > win_score - 4'd1)) begin
      r.scorer = win_score - 4'd1;
      r.other  = win_score - 4'd1;
    end
`else
    r.win = (r.scorer >= win_score);
`endif
    return r;
  endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match-controller bundle between physics/UI (master) and pong_match_ctrl (slave).
interface pong_match_ctrl_if;
  logic       start;
  logic       player_point;
  logic       opp_point;
  logic       ball_run;
  logic       serve_dir_x;
  logic [7:0] score;
  logic       game_over;
  logic       winner;

  modport master (output start, player_point, opp_point,
                  input  ball_run, serve_dir_x, score, game_over, winner);
  modport slave  (input  start, player_point, opp_point,
                  output ball_run, serve_dir_x, score, game_over, winner);
endinterface

// File: rtl/pong_tick_timer.sv
// Loadable up-counter with terminal-count flag at SERVE_TICKS-1.
module pong_tick_timer #(
  parameter int unsigned SERVE_TICKS = 30
) (
  input  logic clk_div,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [5:0] cnt;

  always_ff @(posedge clk_div) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + 6'd1;
  end

  assign tc = (cnt == 6'(SERVE_TICKS - 1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve/play/game-over and keeps the packed score.
// PONG_WIN_BY_TWO_EN (via pong_pkg::award_point) enables win-by-two scoring.
//   state | meaning
//   IDLE  | power-up, ball held, waiting for start edge
//   SERVE | ball held at centre for SERVE_TICKS ticks
//   PLAY  | ball live, point pulses scored
//   OVER  | match won, score frozen until start edge
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_TICKS = 30
) (
  input  logic                clk_div,
  input  logic                rst_n,
  pong_match_ctrl_if.slave    bus
);

  localparam logic [SCORE_W-1:0] WIN4 = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic [SCORE_W-1:0] score_p, score_o;
  logic               start_q, ball_run_r, serve_dir_r, game_over_r, winner_r;
  logic               start_edge, serve_done;
  pt_res_t            res_p, res_o;

  pong_tick_timer #(.SERVE_TICKS(SERVE_TICKS)) u_serve_timer (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .load    (state != SERVE),
    .en      (state == SERVE),
    .tc      (serve_done)
  );

  assign start_edge = bus.start & ~start_q;
  assign res_p      = award_point(score_p, score_o, WIN4);
  assign res_o      = award_point(score_o, score_p, WIN4);

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state       <= IDLE;
      score_p     <= '0;
      score_o     <= '0;
      start_q     <= 1'b0;
      ball_run_r  <= 1'b0;
      serve_dir_r <= 1'b1;
      game_over_r <= 1'b0;
      winner_r    <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state)
        IDLE:  if (start_edge) state <= SERVE;
        SERVE: if (serve_done) begin
          state      <= PLAY;
          ball_run_r <= 1'b1;
        end
        PLAY: begin
          if (bus.player_point || bus.opp_point) begin
            ball_run_r <= 1'b0;
            state      <= SERVE;
          end
          // Simultaneous pulses are a physics ambiguity: replay the serve, score nothing.
          if (bus.player_point && !bus.opp_point) begin
            score_p     <= res_p.scorer;
            score_o     <= res_p.other;
            serve_dir_r <= 1'b0;
            if (res_p.win) begin
              state       <= OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b1;
            end
          end else if (bus.opp_point && !bus.player_point) begin
            score_o     <= res_o.scorer;
            score_p     <= res_o.other;
            serve_dir_r <= 1'b1;
            if (res_o.win) begin
              state       <= OVER;
              game_over_r <= 1'b1;
              winner_r    <= 1'b0;
            end
          end
        end
        OVER: if (start_edge) begin
          score_p     <= '0;
          score_o     <= '0;
          game_over_r <= 1'b0;
          state       <= SERVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ball_run    = ball_run_r;
  assign bus.serve_dir_x = serve_dir_r;
  assign bus.score       = {score_o, score_p};
  assign bus.game_over   = game_over_r;
  assign bus.winner      = winner_r;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl (WIN_SCORE=11, SERVE_TICKS=30).
module tb_pong_match_ctrl;

  localparam int SERVE_TICKS = 30;

  logic clk_div = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_div = ~clk_div;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(.WIN_SCORE(11), .SERVE_TICKS(SERVE_TICKS)) dut (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] score;
    logic       dir;
    logic       go;
    logic       win;
  } exp_t;

  typedef struct {
    logic       pp;
    logic       op;
    logic [7:0] score;
    logic       dir;
    logic       go;
    logic       win;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // After SERVE is entered, ball_run must rise exactly SERVE_TICKS ticks later.
  task automatic wait_serve(input string name);
    int n = 0;
    chk({name, "_held"}, 32'(bus.ball_run), 32'd0);
    while (!bus.ball_run && n < 200) begin
      @(negedge clk_div);
      n++;
    end
    chk({name, "_pause"}, n, SERVE_TICKS);
  endtask

  task automatic do_point(input logic pp, input logic op, input logic [7:0] e_score,
                          input logic e_dir, input logic e_go, input logic e_win);
    exp_t e, got;
    e.score = e_score; e.dir = e_dir; e.go = e_go; e.win = e_win;
    sb.push_back(e);
    bus.player_point = pp;
    bus.opp_point    = op;
    @(negedge clk_div);
    bus.player_point = 1'b0;
    bus.opp_point    = 1'b0;
    got = sb.pop_front();
    chk("score", 32'(bus.score), 32'(got.score));
    chk("serve_dir", 32'(bus.serve_dir_x), 32'(got.dir));
    chk("game_over", 32'(bus.game_over), 32'(got.go));
    if (got.go) chk("winner", 32'(bus.winner), 32'(got.win));
    if (!got.go) wait_serve("point");
    else chk("ball_run_over", 32'(bus.ball_run), 32'd0);
  endtask

  task automatic start_pulse(input logic [7:0] e_score);
    bus.start = 1'b1;
    @(negedge clk_div);
    chk("start_score", 32'(bus.score), 32'(e_score));
    chk("start_go", 32'(bus.game_over), 32'd0);
    wait_serve("start");
    bus.start = 1'b0;
  endtask

  vec_t vecs[$];
  int   ep, eo;

  initial begin
    bus.start = 1'b0; bus.player_point = 1'b0; bus.opp_point = 1'b0;
    vecs = '{
      '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h23, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h23, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h24, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h25, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h26, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h27, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h28, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h29, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h2B, 1'b0, 1'b1, 1'b1}
    };

    repeat (3) @(negedge clk_div);
    chk("rst_score", 32'(bus.score), 32'h00);
    chk("rst_ball_run", 32'(bus.ball_run), 32'd0);
    chk("rst_dir", 32'(bus.serve_dir_x), 32'd1);
    chk("rst_go", 32'(bus.game_over), 32'd0);
    chk("rst_winner", 32'(bus.winner), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_div);
    chk("idle_hold", 32'(bus.ball_run), 32'd0);

    start_pulse(8'h00);

    foreach (vecs[i])
      do_point(vecs[i].pp, vecs[i].op, vecs[i].score, vecs[i].dir, vecs[i].go, vecs[i].win);

    // Points in OVER are ignored.
    bus.player_point = 1'b1;
    @(negedge clk_div);
    bus.player_point = 1'b0;
    bus.opp_point    = 1'b1;
    @(negedge clk_div);
    bus.opp_point    = 1'b0;
    chk("over_frozen", 32'(bus.score), 32'h2B);
    chk("over_held", 32'(bus.game_over), 32'd1);

    start_pulse(8'h00);
    chk("restart_dir", 32'(bus.serve_dir_x), 32'd0);

    // Build 0x57, ending on a player point, then check start in PLAY is ignored.
    ep = 0; eo = 0;
    for (int k = 0; k < 5; k++) begin
      eo++; do_point(1'b0, 1'b1, 8'((eo << 4) | ep), 1'b1, 1'b0, 1'b0);
      ep++; do_point(1'b1, 1'b0, 8'((eo << 4) | ep), 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      ep++; do_point(1'b1, 1'b0, 8'((eo << 4) | ep), 1'b0, 1'b0, 1'b0);
    end
    chk("pre_rst_score", 32'(bus.score), 32'h57);
    bus.start = 1'b1;
    @(negedge clk_div);
    bus.start = 1'b0;
    chk("play_start_ignored", 32'(bus.ball_run), 32'd1);

    // Reset overrides a simultaneous point.
    rst_n = 1'b0;
    bus.player_point = 1'b1;
    @(negedge clk_div);
    bus.player_point = 1'b0;
    chk("mid_rst_score", 32'(bus.score), 32'h00);
    chk("mid_rst_ball_run", 32'(bus.ball_run), 32'd0);
    chk("mid_rst_dir", 32'(bus.serve_dir_x), 32'd1);
    chk("mid_rst_go", 32'(bus.game_over), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_div);
    repeat (5) @(negedge clk_div);
    chk("mid_rst_idle", 32'(bus.ball_run), 32'd0);

`ifdef PONG_WIN_BY_TWO_EN
    start_pulse(8'h00);
    ep = 0; eo = 0;
    for (int k = 0; k < 10; k++) begin
      ep++; do_point(1'b1, 1'b0, 8'((eo << 4) | ep), 1'b0, 1'b0, 1'b0);
      eo++; do_point(1'b0, 1'b1, 8'((eo << 4) | ep), 1'b1, 1'b0, 1'b0);
    end
    do_point(1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b0);
    do_point(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    do_point(1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 1'b0);
    do_point(1'b1, 1'b0, 8'hAC, 1'b0, 1'b1, 1'b1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
